// File: rtl/fifo_share_pkg.sv
// Shared definitions for the multi-requester FIFO: default sizes and the
// source-index width helper used to size the per-entry requester tag.
package fifo_share_pkg;

    localparam int unsigned DEF_N_REQ = 32'd4;
    localparam int unsigned DEF_WIDTH = 32'd8;
    localparam int unsigned DEF_DEPTH = 32'd8;

    // Width of a requester index; never collapses below one bit
    function automatic int unsigned src_width(input int unsigned n_req);
        return (n_req > 32'd1) ? $clog2(n_req) : 32'd1;
    endfunction

    // The {src, data} entry struct is sized by module parameters, so each
    // user declares it locally from src_width() and its own WIDTH.

endpackage

// File: rtl/fifo_share_arbiter_chk.sv
// Simulation-only parameter check for the shared FIFO.
module fifo_share_arbiter_chk #(
    parameter int unsigned DEPTH = 32'd8
) (
    input logic clk
);

    // Pointer wrap relies on natural binary overflow of the extended pointers
    a_depth_pow2: assert property (@(posedge clk) ((DEPTH & (DEPTH - 32'd1)) == 32'd0));

endmodule

// File: rtl/fifo_share_arbiter_rr_pick.sv
// Combinational round-robin search: first set request strictly after the
// last grant, wrapping modulo N_REQ.
module rr_pick #(
    parameter int unsigned N_REQ = 32'd4,
    parameter int unsigned SW    = 32'd2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [SW-1:0]    i_last_grant,
    output logic [N_REQ-1:0] o_grant,
    output logic [SW-1:0]    o_grant_idx,
    output logic             o_grant_any
);

    logic [SW-1:0] w_idx;
    logic          w_hit;

    // Walk the requesters in priority order; the first hit latches the grant
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        w_idx       = '0;
        w_hit       = 1'b0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            w_idx          = SW'((int'(i_last_grant) + k) % int'(N_REQ));
            w_hit          = i_req[w_idx] & ~o_grant_any;
            o_grant[w_idx] = o_grant[w_idx] | w_hit;
            o_grant_idx    = w_hit ? w_idx : o_grant_idx;
            o_grant_any    = o_grant_any | w_hit;
        end
    end

endmodule

// File: rtl/fifo_share_arbiter.sv
// N_REQ requesters share one FIFO through a round-robin push arbiter; each
// stored word carries the index of the requester that pushed it.
module fifo_share_arbiter
    import fifo_share_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(N_REQ)-1:0]   out_src,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full
);

    localparam int unsigned SW = src_width(N_REQ);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [SW-1:0] LAST_RST = SW'(N_REQ - 32'd1);

    typedef struct packed {
        logic [SW-1:0]    src;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [SW-1:0] r_last_grant;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [N_REQ-1:0] w_req_mask;
    logic [N_REQ-1:0] w_grant;
    logic [SW-1:0]    w_grant_idx;
    logic             w_grant_any;
    logic [WIDTH-1:0] w_push_data;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // A pop in the same cycle does not open a slot for a push while full
    assign w_req_mask = (rst_n && !w_full) ? req_valid : '0;

    rr_pick #(
        .N_REQ (N_REQ),
        .SW    (SW)
    ) u_rr_pick (
        .i_req        (w_req_mask),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_grant_any  (w_grant_any)
    );

    assign w_push = w_grant_any;
    assign w_pop  = ~w_empty & out_ready;

    // Select the granted requester's word with a one-hot AND-OR mux
    always_comb begin
        w_push_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            w_push_data = w_push_data | ({WIDTH{w_grant[i]}} & req_data[i*WIDTH +: WIDTH]);
        end
    end

    // Storage array; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= '{src: w_grant_idx, data: w_push_data};
        end
    end

    // Pointers and round-robin history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_last_grant <= LAST_RST;
        end else begin
            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + PTR_ONE;
                r_last_grant <= w_grant_idx;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    assign req_ready = w_grant;
    assign out_valid = ~w_empty;
    assign out_data  = r_mem[r_rd_ptr[AW-1:0]].data;
    assign out_src   = r_mem[r_rd_ptr[AW-1:0]].src;
    assign level     = r_wr_ptr - r_rd_ptr;
    assign full      = w_full;

endmodule

// File: tb/tb_fifo_share_arbiter.sv
// Directed vector table, reset-mid-traffic sequence and a randomised
// scoreboard run for the shared-FIFO arbiter.
module tb_fifo_share_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rv;
    logic [31:0] rdata_bus;
    logic [3:0]  ready;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  osrc;
    logic        ordy;
    logic [3:0]  lvl;
    logic        full;

    always #5 clk = ~clk;

    fifo_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (rv),
        .req_data  (rdata_bus),
        .req_ready (ready),
        .out_valid (ov),
        .out_data  (od),
        .out_src   (osrc),
        .out_ready (ordy),
        .level     (lvl),
        .full      (full)
    );

    fifo_share_arbiter_chk #(.DEPTH(DEPTH)) u_chk (.clk(clk));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] rv;
        logic       ordy;
        logic [3:0] e_ready;
        logic       e_valid;
        int         e_src;
        int         e_level;
        logic       e_full;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] r, input logic o, input logic [3:0] er,
                                input logic ev, input int es, input int el, input logic ef);
        vec_t v;
        v.rv = r; v.ordy = o; v.e_ready = er; v.e_valid = ev;
        v.e_src = es; v.e_level = el; v.e_full = ef;
        vecs.push_back(v);
    endfunction

    function automatic logic [3:0] exp_grant(input logic [3:0] m, input int last);
        for (int k = 1; k <= 4; k++) begin
            int idx = (last + k) % 4;
            if (m[idx]) return 4'(1 << idx);
        end
        return 4'b0000;
    endfunction

    typedef struct {
        int src;
        int data;
    } ent_t;

    ent_t       m_q[$];
    int         m_last;
    int         wait_cnt[4];
    logic [7:0] rdat[4];
    logic [3:0] clr;
    logic [3:0] mask;
    logic [3:0] eg;
    int         idx;

    initial begin
        // Fill phase, full stall, full drain with wrap
        for (int k = 0; k < 8; k++) add(4'hF, 1'b0, 4'(1 << (k % 4)), k != 0, 0, k, 1'b0);
        add(4'hF, 1'b0, 4'b0000, 1'b1, 0, 8, 1'b1);
        for (int k = 0; k < 8; k++) add(4'h0, 1'b1, 4'b0000, 1'b1, k % 4, 8 - k, k == 0);
        add(4'h0, 1'b0, 4'b0000, 1'b0, 0, 0, 1'b0);
        // Refill, then pop while full: no push that cycle, push the next
        for (int k = 0; k < 8; k++) add(4'hF, 1'b0, 4'(1 << (k % 4)), k != 0, 0, k, 1'b0);
        add(4'hF, 1'b1, 4'b0000, 1'b1, 0, 8, 1'b1);
        add(4'hF, 1'b0, 4'b0001, 1'b1, 1, 7, 1'b0);
        add(4'h0, 1'b0, 4'b0000, 1'b1, 1, 8, 1'b1);
        for (int k = 0; k < 8; k++) add(4'h0, 1'b1, 4'b0000, 1'b1, (k + 1) % 4, 8 - k, k == 0);
        // Single requester streaming through an otherwise empty FIFO
        add(4'b0100, 1'b1, 4'b0100, 1'b0, 0, 0, 1'b0);
        for (int k = 0; k < 3; k++) add(4'b0100, 1'b1, 4'b0100, 1'b1, 2, 1, 1'b0);
        add(4'h0, 1'b1, 4'b0000, 1'b1, 2, 1, 1'b0);
        add(4'h0, 1'b0, 4'b0000, 1'b0, 0, 0, 1'b0);
        // Sparse masks exercising the wrap of the priority search
        add(4'b1010, 1'b0, 4'b1000, 1'b0, 0, 0, 1'b0);
        add(4'b1010, 1'b0, 4'b0010, 1'b1, 3, 1, 1'b0);
        add(4'b0011, 1'b0, 4'b0001, 1'b1, 3, 2, 1'b0);
        add(4'b0011, 1'b0, 4'b0010, 1'b1, 3, 3, 1'b0);
        add(4'h0, 1'b1, 4'b0000, 1'b1, 3, 4, 1'b0);

        rst_n = 1'b0;
        rv = 4'hF;
        ordy = 1'b1;
        rdata_bus = 32'hA3A2A1A0;
        @(negedge clk);
        #1;
        chk("rst ready", ready, 0);
        chk("rst out_valid", ov, 0);
        chk("rst level", lvl, 0);
        chk("rst full", full, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rv = 4'h0;

        foreach (vecs[i]) begin
            @(negedge clk);
            rv = vecs[i].rv;
            ordy = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d ready", i), ready, vecs[i].e_ready);
            chk($sformatf("v%0d out_valid", i), ov, vecs[i].e_valid);
            chk($sformatf("v%0d level", i), lvl, vecs[i].e_level);
            chk($sformatf("v%0d full", i), full, vecs[i].e_full);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d out_src", i), osrc, vecs[i].e_src);
                chk($sformatf("v%0d out_data", i), od, 32'hA0 + vecs[i].e_src);
            end
        end

        // Reset pulse at level 5 while requests are active
        @(negedge clk);
        rv = 4'hF;
        ordy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre-reset level", lvl, 5);
        rst_n = 1'b0;
        #1;
        chk("async rst level", lvl, 0);
        chk("async rst out_valid", ov, 0);
        chk("async rst full", full, 0);
        chk("async rst ready", ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset first grant", ready, 4'b0001);
        @(negedge clk);
        rv = 4'h0;
        #1;
        chk("post-reset level", lvl, 1);
        chk("post-reset out_src", osrc, 0);
        chk("post-reset out_data", od, 32'hA0);

        // Randomised run against a queue model
        @(negedge clk);
        rst_n = 1'b0;
        rv = 4'h0;
        ordy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_last = 3;
        clr = 4'h0;
        for (int i = 0; i < 4; i++) begin
            wait_cnt[i] = 0;
            rdat[i] = 8'h00;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            rv = rv & ~clr;
            clr = 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (!rv[i] && $urandom_range(0, 2) == 0) begin
                    rv[i] = 1'b1;
                    rdat[i] = 8'($urandom_range(0, 255));
                    wait_cnt[i] = 0;
                end
                rdata_bus[i*8 +: 8] = rdat[i];
            end
            ordy = ($urandom_range(0, 9) < (((cyc / 200) % 2 != 0) ? 3 : 8));
            #1;
            mask = (m_q.size() == DEPTH) ? 4'h0 : rv;
            eg = exp_grant(mask, m_last);
            chk("rnd ready", ready, eg);
            chk("rnd out_valid", ov, m_q.size() != 0);
            chk("rnd level", lvl, m_q.size());
            chk("rnd full", full, m_q.size() == DEPTH);
            if (m_q.size() != 0) begin
                chk("rnd out_src", osrc, m_q[0].src);
                chk("rnd out_data", od, m_q[0].data);
            end
            if (m_q.size() != 0 && ordy) void'(m_q.pop_front());
            if (eg != 4'h0) begin
                idx = 0;
                for (int j = 0; j < 4; j++) if (eg[j]) idx = j;
                checks++;
                if (wait_cnt[idx] >= N_REQ) begin
                    errors++;
                    $display("FAIL starvation req%0d: waited %0d pushes, bound %0d", idx, wait_cnt[idx], N_REQ - 1);
                end
                m_q.push_back('{idx, int'(rdat[idx])});
                m_last = idx;
                clr[idx] = 1'b1;
                for (int j = 0; j < 4; j++) if (j != idx && rv[j]) wait_cnt[j]++;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
